// File: rtl/ram_pkg.sv
// Shared widths, port ids and request record for the ALU-RAM data RAM arbiter.
package ram_pkg;

   localparam int ADDR_W = 4;
   localparam int DATA_W = 32;

   localparam logic PORT_ALU  = 1'b0;
   localparam logic PORT_HOST = 1'b1;

   typedef struct packed {
      logic              we;
      logic [ADDR_W-1:0] addr;
      logic [DATA_W-1:0] wdata;
   } ram_req_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter: the port that did not win last time wins a tie.
import ram_pkg::*;

module rr_arb2 (
   input  logic       clk,
   input  logic       rst,
   input  logic [1:0] valid,
   output logic [1:0] grant,
   output logic       last_grant
);

   // Grant is held off entirely while reset is asserted so nothing is accepted.
   always_comb begin
      grant = 2'b00;
      if (!rst) begin
         if (valid == 2'b11) begin
            grant = last_grant ? 2'b01 : 2'b10;
         end else begin
            grant = valid;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         last_grant <= PORT_HOST;
      end else if (grant != 2'b00) begin
         last_grant <= grant[1];
      end
   end

endmodule

// File: rtl/ram_port_arbiter.sv
// Round-robin sequencer between the ALU and host ports and the single-port data RAM,
// with a registered issue stage and a per-port read response demux.
import ram_pkg::*;

module ram_port_arbiter (
   input  logic              clk,
   input  logic              rst,

   input  logic              p0_req_valid,
   output logic              p0_req_ready,
   input  logic              p0_req_we,
   input  logic [ADDR_W-1:0] p0_req_addr,
   input  logic [DATA_W-1:0] p0_req_wdata,
   output logic              p0_rsp_valid,
   output logic [DATA_W-1:0] p0_rsp_data,

   input  logic              p1_req_valid,
   output logic              p1_req_ready,
   input  logic              p1_req_we,
   input  logic [ADDR_W-1:0] p1_req_addr,
   input  logic [DATA_W-1:0] p1_req_wdata,
   output logic              p1_rsp_valid,
   output logic [DATA_W-1:0] p1_rsp_data,

   output logic              ram_w_en,
   output logic              ram_r_en,
   output logic [ADDR_W-1:0] ram_addr_r,
   output logic [ADDR_W-1:0] ram_addr_w,
   output logic [DATA_W-1:0] ram_wdata,
   input  logic [DATA_W-1:0] ram_rdata
);

   logic [1:0] grant;
   logic       last_grant;
   logic       any_grant;
   logic       iss_port;
   logic       iss_rd;
   ram_req_t   req;

   rr_arb2 u_arb (
      .clk        (clk),
      .rst        (rst),
      .valid      ({p1_req_valid, p0_req_valid}),
      .grant      (grant),
      .last_grant (last_grant)
   );

   assign p0_req_ready = grant[0];
   assign p1_req_ready = grant[1];
   assign any_grant    = |grant;

   // The pointer is rewritten on every grant, so it already names the port in the issue stage.
   assign iss_port = last_grant;
   assign iss_rd   = ram_r_en;

   always_comb begin
      req = '{we: p0_req_we, addr: p0_req_addr, wdata: p0_req_wdata};
      if (grant[1]) begin
         req = '{we: p1_req_we, addr: p1_req_addr, wdata: p1_req_wdata};
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ram_w_en   <= 1'b0;
         ram_r_en   <= 1'b0;
         ram_addr_r <= '0;
         ram_addr_w <= '0;
         ram_wdata  <= '0;
      end else begin
         ram_w_en <= any_grant && req.we;
         ram_r_en <= any_grant && !req.we;
         if (any_grant) begin
            ram_addr_r <= req.addr;
            ram_addr_w <= req.addr;
            if (req.we) begin
               ram_wdata <= req.wdata;
            end
         end
      end
   end

   // RAM data is valid at this edge because the RAM updated it on the preceding negedge.
   always_ff @(posedge clk) begin
      if (rst) begin
         p0_rsp_valid <= 1'b0;
         p1_rsp_valid <= 1'b0;
         p0_rsp_data  <= '0;
         p1_rsp_data  <= '0;
      end else begin
         p0_rsp_valid <= iss_rd && (iss_port == PORT_ALU);
         p1_rsp_valid <= iss_rd && (iss_port == PORT_HOST);
         if (iss_rd && (iss_port == PORT_ALU)) begin
            p0_rsp_data <= ram_rdata;
         end
         if (iss_rd && (iss_port == PORT_HOST)) begin
            p1_rsp_data <= ram_rdata;
         end
      end
   end

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed bench for ram_port_arbiter: negedge RAM model, transaction-level shadow model, per-cycle compare.
module tb_ram_port_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic        p0_req_valid, p0_req_ready, p0_req_we, p0_rsp_valid;
   logic [3:0]  p0_req_addr;
   logic [31:0] p0_req_wdata, p0_rsp_data;
   logic        p1_req_valid, p1_req_ready, p1_req_we, p1_rsp_valid;
   logic [3:0]  p1_req_addr;
   logic [31:0] p1_req_wdata, p1_rsp_data;
   logic        ram_w_en, ram_r_en;
   logic [3:0]  ram_addr_r, ram_addr_w;
   logic [31:0] ram_wdata;
   logic [31:0] ram_rdata = 32'h0;

   int checks = 0;
   int errors = 0;

   ram_port_arbiter dut (
      .clk          (clk),
      .rst          (rst),
      .p0_req_valid (p0_req_valid),
      .p0_req_ready (p0_req_ready),
      .p0_req_we    (p0_req_we),
      .p0_req_addr  (p0_req_addr),
      .p0_req_wdata (p0_req_wdata),
      .p0_rsp_valid (p0_rsp_valid),
      .p0_rsp_data  (p0_rsp_data),
      .p1_req_valid (p1_req_valid),
      .p1_req_ready (p1_req_ready),
      .p1_req_we    (p1_req_we),
      .p1_req_addr  (p1_req_addr),
      .p1_req_wdata (p1_req_wdata),
      .p1_rsp_valid (p1_rsp_valid),
      .p1_rsp_data  (p1_rsp_data),
      .ram_w_en     (ram_w_en),
      .ram_r_en     (ram_r_en),
      .ram_addr_r   (ram_addr_r),
      .ram_addr_w   (ram_addr_w),
      .ram_wdata    (ram_wdata),
      .ram_rdata    (ram_rdata)
   );

   always #5 clk = ~clk;

   // The RAM itself: executes on the falling edge, registered read data.
   logic [31:0] ram_mem [16];
   initial foreach (ram_mem[i]) ram_mem[i] = 32'h0;
   always @(negedge clk) begin
      if (ram_w_en === 1'b1) ram_mem[ram_addr_w] <= ram_wdata;
      if (ram_r_en === 1'b1) ram_rdata <= ram_mem[ram_addr_r];
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: requests become transactions; a read returns the shadow-memory word two cycles after acceptance.
   logic [31:0] m_mem [16];
   logic        m_last = 1'b1;
   logic        model_live = 1'b0;
   logic        e_w_en = 1'b0, e_r_en = 1'b0;
   logic [3:0]  e_addr = 4'h0;
   logic [31:0] e_wdata = 32'h0;
   logic        e_v0 = 1'b0, e_v1 = 1'b0;
   logic [31:0] e_d0 = 32'h0, e_d1 = 32'h0;
   logic        pend_v = 1'b0;
   int          pend_p = 0;
   logic [31:0] pend_d = 32'h0;
   initial foreach (m_mem[i]) m_mem[i] = 32'h0;

   function automatic int winner(input logic v0, input logic v1, input logic last);
      if (v0 && v1) return last ? 0 : 1;
      if (v0) return 0;
      if (v1) return 1;
      return -1;
   endfunction

   always @(posedge clk) begin
      int w;
      model_live = 1'b1;
      if (rst) begin
         m_last = 1'b1;
         e_w_en = 1'b0; e_r_en = 1'b0; e_addr = 4'h0; e_wdata = 32'h0;
         e_v0 = 1'b0; e_v1 = 1'b0; e_d0 = 32'h0; e_d1 = 32'h0;
         pend_v = 1'b0;
      end else begin
         e_v0 = pend_v && pend_p == 0;
         e_v1 = pend_v && pend_p == 1;
         if (e_v0) e_d0 = pend_d;
         if (e_v1) e_d1 = pend_d;
         pend_v = 1'b0;
         e_w_en = 1'b0; e_r_en = 1'b0;
         w = winner(p0_req_valid, p1_req_valid, m_last);
         if (w >= 0) begin
            logic        we;
            logic [3:0]  a;
            logic [31:0] d;
            we = (w == 0) ? p0_req_we : p1_req_we;
            a  = (w == 0) ? p0_req_addr : p1_req_addr;
            d  = (w == 0) ? p0_req_wdata : p1_req_wdata;
            e_addr = a;
            if (we) begin
               m_mem[a] = d; e_w_en = 1'b1; e_wdata = d;
            end else begin
               e_r_en = 1'b1; pend_v = 1'b1; pend_p = w; pend_d = m_mem[a];
            end
            m_last = (w == 1);
         end
      end
   end

   always @(negedge clk) begin
      if (model_live) begin
         int w;
         w = rst ? -1 : winner(p0_req_valid, p1_req_valid, m_last);
         checkOutput("p0_req_ready", p0_req_ready, w == 0);
         checkOutput("p1_req_ready", p1_req_ready, w == 1);
         checkOutput("ram_w_en", ram_w_en, e_w_en);
         checkOutput("ram_r_en", ram_r_en, e_r_en);
         checkOutput("en_exclusive", ram_w_en & ram_r_en, 1'b0);
         if (e_w_en) checkOutput("ram_addr_w", ram_addr_w, e_addr);
         if (e_w_en) checkOutput("ram_wdata", ram_wdata, e_wdata);
         if (e_r_en) checkOutput("ram_addr_r", ram_addr_r, e_addr);
         checkOutput("p0_rsp_valid", p0_rsp_valid, e_v0);
         checkOutput("p1_rsp_valid", p1_rsp_valid, e_v1);
         checkOutput("p0_rsp_data", p0_rsp_data, e_d0);
         checkOutput("p1_rsp_data", p1_rsp_data, e_d1);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic applyStimulus(input int port, input logic we, input logic [3:0] addr, input logic [31:0] wdata);
      if (port == 0) begin
         p0_req_valid = 1'b1; p0_req_we = we; p0_req_addr = addr; p0_req_wdata = wdata;
      end else begin
         p1_req_valid = 1'b1; p1_req_we = we; p1_req_addr = addr; p1_req_wdata = wdata;
      end
   endtask

   task automatic dropPort(input int port);
      if (port == 0) p0_req_valid = 1'b0;
      else p1_req_valid = 1'b0;
   endtask

   task automatic waitAccept(input int port);
      logic acc;
      acc = 1'b0;
      for (int i = 0; i < 20 && !acc; i++) begin
         @(negedge clk);
         acc = (port == 0) ? p0_req_ready : p1_req_ready;
         tick();
      end
      if (!acc) checkOutput("accept_timeout", 32'd0, 32'd1);
   endtask

   task automatic doWrite(input int port, input logic [3:0] addr, input logic [31:0] data);
      applyStimulus(port, 1'b1, addr, data);
      waitAccept(port);
      dropPort(port);
   endtask

   logic [31:0] got_d [$];
   int          got_c [$];

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not end");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      rst = 1'b1;
      p0_req_valid = 1'b0; p0_req_we = 1'b0; p0_req_addr = 4'h0; p0_req_wdata = 32'h0;
      p1_req_valid = 1'b0; p1_req_we = 1'b0; p1_req_addr = 4'h0; p1_req_wdata = 32'h0;

      // Reset held with both requesters asking
      applyStimulus(0, 1'b0, 4'h0, 32'h0);
      applyStimulus(1, 1'b0, 4'h0, 32'h0);
      repeat (3) tick();
      @(negedge clk);
      checkOutput("rst_p0_ready", p0_req_ready, 1'b0);
      checkOutput("rst_p1_ready", p1_req_ready, 1'b0);
      checkOutput("rst_r_en", ram_r_en, 1'b0);
      checkOutput("rst_p0_rsp_data", p0_rsp_data, 32'h0);
      dropPort(0); dropPort(1);
      tick();
      rst = 1'b0;
      tick();

      // Write then read on port 0
      doWrite(0, 4'd3, 32'hDEADBEEF);
      applyStimulus(0, 1'b0, 4'd3, 32'h0);
      waitAccept(0);
      dropPort(0);
      tick();
      @(negedge clk);
      checkOutput("wr_rd_p0_valid", p0_rsp_valid, 1'b1);
      checkOutput("wr_rd_p0_data", p0_rsp_data, 32'hDEADBEEF);
      checkOutput("wr_rd_p1_valid", p1_rsp_valid, 1'b0);
      repeat (2) tick();

      // Contention: port 1 wrote last, so port 0 wins first and grants alternate
      doWrite(0, 4'd1, 32'h11);
      doWrite(1, 4'd2, 32'h22);
      tick();
      applyStimulus(0, 1'b0, 4'd1, 32'h0);
      applyStimulus(1, 1'b0, 4'd2, 32'h0);
      @(negedge clk);
      checkOutput("cont_first_p0", p0_req_ready, 1'b1);
      checkOutput("cont_first_p1", p1_req_ready, 1'b0);
      repeat (8) tick();
      dropPort(0); dropPort(1);
      repeat (3) tick();
      checkOutput("cont_p0_data", p0_rsp_data, 32'h11);
      checkOutput("cont_p1_data", p1_rsp_data, 32'h22);

      // Read-after-write across ports
      doWrite(1, 4'd15, 32'h12345678);
      applyStimulus(0, 1'b0, 4'd15, 32'h0);
      waitAccept(0);
      dropPort(0);
      tick();
      @(negedge clk);
      checkOutput("raw_p0_valid", p0_rsp_valid, 1'b1);
      checkOutput("raw_p0_data", p0_rsp_data, 32'h12345678);
      repeat (2) tick();

      // Reset the cycle after a port 1 read is accepted
      applyStimulus(1, 1'b0, 4'd2, 32'h0);
      waitAccept(1);
      dropPort(1);
      rst = 1'b1;
      tick();
      @(negedge clk);
      checkOutput("mid_rst_r_en", ram_r_en, 1'b0);
      checkOutput("mid_rst_p1_valid", p1_rsp_valid, 1'b0);
      tick();
      @(negedge clk);
      checkOutput("mid_rst_p1_valid2", p1_rsp_valid, 1'b0);
      applyStimulus(0, 1'b0, 4'd1, 32'h0);
      applyStimulus(1, 1'b0, 4'd2, 32'h0);
      tick();
      rst = 1'b0;
      @(negedge clk);
      checkOutput("post_rst_p0_wins", p0_req_ready, 1'b1);
      checkOutput("post_rst_p1_waits", p1_req_ready, 1'b0);
      tick();
      dropPort(0); dropPort(1);
      repeat (4) tick();

      // Streaming: four back-to-back reads from port 0
      for (int i = 0; i < 4; i++) doWrite(1, 4'(i), 32'hA0 + 32'(i));
      tick();
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               applyStimulus(0, 1'b0, 4'(i), 32'h0);
               @(negedge clk);
               checkOutput("stream_ready", p0_req_ready, 1'b1);
               tick();
            end
            dropPort(0);
         end
         begin
            for (int c = 0; c < 8; c++) begin
               @(negedge clk);
               if (p0_rsp_valid === 1'b1) begin
                  got_d.push_back(p0_rsp_data);
                  got_c.push_back(c);
               end
            end
         end
      join
      checkOutput("stream_count", 32'(got_d.size()), 32'd4);
      for (int i = 0; i < 4 && i < got_d.size(); i++) begin
         checkOutput("stream_data", got_d[i], 32'hA0 + 32'(i));
         checkOutput("stream_consecutive", 32'(got_c[i] - got_c[0]), 32'(i));
      end
      repeat (3) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ram_port_arbiter.md
# ram_port_arbiter

Two-requester, round-robin arbiter and sequencer for the 16x32 single-port-per-cycle data RAM in the ALU-RAM datapath. It accepts read/write requests from port 0 (ALU datapath) and port 1 (host/loader) over valid/ready handshakes and issues at most one RAM operation per cycle, never asserting read and write enables together. It routes registered read data back to the requester that issued the read. It sits between the two requesters and the RAM's `clk`/`w_en`/`r_en`/`addr_*`/`s_ALU`/`s_RAM` pins.

## Interface
- `ADDR_W`, 4: RAM address width (16 words).
- `DATA_W`, 32: data width.

Clocking and reset:
- `clk` in 1: single clock; arbiter logic is posedge, RAM is negedge.
- `rst` in 1: synchronous, active-high reset.

Requester ports, for N = 0 and 1:
- `pN_req_valid` in 1: request present.
- `pN_req_ready` out 1: request accepted this cycle.
- `pN_req_we` in 1: 1 = write, 0 = read.
- `pN_req_addr` in ADDR_W: word address.
- `pN_req_wdata` in DATA_W: write data.
- `pN_rsp_valid` out 1: one-cycle pulse, read data valid.
- `pN_rsp_data` out DATA_W: read data.

RAM side:
- `ram_w_en` out 1: write enable.
- `ram_r_en` out 1: read enable.
- `ram_addr_r` out ADDR_W: read address.
- `ram_addr_w` out ADDR_W: write address.
- `ram_wdata` out DATA_W: write data, to RAM `s_ALU`.
- `ram_rdata` in DATA_W: read data, from RAM `s_RAM`.

## Operation
- **Handshake:**
  - A transfer occurs when `pN_req_valid && pN_req_ready` at a posedge.
  - A requester holds valid and its fields stable until ready.
  - `pN_req_ready` is combinational from the current valids and the pointer only. It does not depend on ready.
- **Arbitration (`last_grant` pointer, 1 bit):**
  - One valid: that port is granted.
  - Both valid: the port not equal to `last_grant` is granted.
  - No valid: no grant.
  - `last_grant` updates only on an actual grant.
- **Issue stage (registered):**
  - On a grant, register `ram_w_en = we` and `ram_r_en = !we`.
  - Both `ram_addr_r` and `ram_addr_w` get `addr`.
  - `ram_wdata` gets `wdata` on writes and holds on reads.
  - Record the issuing port id in `iss_port`.
  - No grant: both enables 0, addresses and data hold.
- **Invariant:** `ram_w_en && ram_r_en` is never 1.
- **Response stage:**
  - If the previous cycle's issue was a read, capture `ram_rdata` into `pN_rsp_data` for N = `iss_port`.
  - Pulse `pN_rsp_valid` for one cycle.
  - The other port's `rsp_data` holds and its valid stays 0.
- **No response backpressure:** requesters must accept `rsp_valid` whenever it is asserted.
- **Reset:**
  - All outputs 0; `last_grant` = 1, so port 0 wins the first contention.
  - Issue and response pipelines are cleared. In-flight reads are dropped and produce no `rsp_valid`.
  - `req_ready` is 0 while `rst` is high.

## Timing
- Request accepted at the posedge ending cycle N.
- `ram_*` command is driven during cycle N+1. The RAM executes at the negedge inside N+1.
- Read data is captured at the posedge ending N+1. `pN_rsp_valid` is high in cycle N+2, giving a read latency of 2 cycles.
- Throughput is one operation per cycle, sustained across both ports.
- A write accepted in cycle N is visible to any read accepted in cycle N+1 or later. No forwarding logic is required.
- Reset asserted at the posedge starting cycle M:
  - Enables are 0 during M, so the RAM sees no operation at M's negedge.
  - Any `rsp_valid` scheduled for M+1 is suppressed.
  - RAM contents are not cleared.
- Address wrap: addresses are ADDR_W bits and are passed through unmodified. There is no range check.

## Structure
- Shared package `ram_pkg`:
  - `ADDR_W`, `DATA_W`
  - `PORT_ALU = 1'b0`, `PORT_HOST = 1'b1`
  - request struct typedef {we, addr, wdata}
- Sub-module `rr_arb2`: 2-way round-robin arbiter. Inputs are valids; outputs are a one-hot grant and the updated `last_grant` register.
- Top level holds the issue registers, `iss_port`/`iss_rd` tracking, and response demux.

## Test plan
- **Reset:** hold `rst` 3 cycles with both valids high → all outputs 0, `req_ready` 0, no RAM enables.
- **Write then read:** p0 writes addr 3 = 0xDEADBEEF, then p0 reads addr 3 → `p0_rsp_valid` 2 cycles after read accept with 0xDEADBEEF; `p1_rsp_valid` stays 0.
- **Contention:** both ports hold reads continuously (p0 addr 1 = 0x11, p1 addr 2 = 0x22) → grants alternate p0, p1, p0, …; each `rsp` carries its own value; enables are never both high.
- **Read-after-write:** p1 writes addr 15 = 0x12345678 in cycle N, p0 reads addr 15 accepted in N+1 → `p0_rsp_data` = 0x12345678 in N+3.
- **Reset mid-operation:** `rst` asserted the cycle after a p1 read is accepted → no `p1_rsp_valid`; `ram_r_en` is 0 in the reset cycle; after release, p0 wins the first contention.
- **Streaming:** p0 alone issues 4 reads (addrs 0–3 preloaded 0xA0–0xA3) → ready every cycle; 4 consecutive `p0_rsp_valid` pulses with 0xA0–0xA3 in order.
